sprite_pixel_compositor: RTL and testbench
==========================================

# sprite_pixel_compositor

Parametrised, pipelined successor to the combinational pixel generator. It composites the following per VGA pixel: a selectable background, NUM_SPRITES positioned sprites read from external synchronous ROMs, and the mouse-cursor overlay. Sprite positions are double-buffered so updates take effect only at the frame boundary, which prevents tearing. The block sits between the VGA timing counter / mouse-cursor logic and the board RGB pins. The top level delays hsync/vsync by LATENCY cycles.

## Interface
Parameters:
- NUM_SPRITES, 4, number of sprite channels (1..8); index 0 has highest priority
- SPRITE_W, 32, sprite width in pixels; power of two
- SPRITE_H, 32, sprite height in pixels
- H_ACTIVE, 640, visible columns
- V_ACTIVE, 480, visible rows
- TRANSPARENT, 12'h0F0, sprite colour key; pixels of this colour are not drawn
- LATENCY, 2, pixel-in to RGB-out delay in cycles; fixed, documents the pipeline

Ports:
- clk  in  1  pixel clock; one pixel per cycle
- rst_n  in  1  asynchronous, active-low reset
- h_cnt  in  10  current column
- v_cnt  in  10  current row
- valid  in  1  h_cnt/v_cnt lie in the active area
- enable_mouse_display  in  1  cursor covers this pixel; aligned with h_cnt
- mouse_pixel  in  12  cursor colour; aligned with h_cnt
- bg_mode  in  2  0 solid, 1 checkerboard, 2 vertical gradient, 3 black
- bg_color  in  12  colour for solid mode and for checkerboard light squares
- cfg_we  in  1  write one sprite's shadow registers
- cfg_idx  in  3  sprite index; writes with cfg_idx >= NUM_SPRITES are ignored
- cfg_x, cfg_y  in  10 each  sprite top-left corner
- cfg_en  in  1  sprite visible
- sprite_addr  out  NUM_SPRITES*log2(SPRITE_W*SPRITE_H)  per-sprite ROM address; registered
- sprite_data  in  NUM_SPRITES*12  ROM data, valid one cycle after sprite_addr
- commit  out  1  one-cycle pulse when shadow registers are copied to active registers
- out_valid  out  1  valid delayed by LATENCY
- vgaRed, vgaGreen, vgaBlue  out  4 each  registered colour

## Operation
- Registers: for each sprite, a shadow {x, y, en} and an active {x, y, en}.
- cfg_we writes the shadow copy in the next cycle. The most recent write wins.
- Commit cycle: the single cycle in which h_cnt==0 and v_cnt==V_ACTIVE. All active registers are loaded from shadow, and commit pulses high for one cycle.
- Write and commit in the same cycle: the commit copies the old shadow value. The new write lands in shadow and is committed next frame.
- Stage 1, on the input cycle:
  - Hit test per sprite: en && h>=x && h<x+SPRITE_W && v>=y && v<y+SPRITE_H. Compare in 11 bits so x+SPRITE_W never wraps.
  - sprite_addr = {(v-y)[rows], (h-x)[log2 SPRITE_W-1:0]}. The address holds its last value when there is no hit.
  - Register the hit vector, background colour, mouse enable/pixel and valid.
- Background colour, computed in stage 1:
  - Solid: bg_color.
  - Checkerboard: 16×16 squares; bg_color when h[4]^v[4]==0, otherwise 12'h000.
  - Gradient: {v[8:5], v[8:5], 4'hF}.
- Stage 2 colour selection, highest priority first:
  1. !valid_d gives 0.
  2. mouse_en_d gives mouse_pixel_d.
  3. The lowest-index sprite with hit_d[i] and sprite_data[i] != TRANSPARENT gives sprite_data[i].
  4. Otherwise, background_d.
- Reset values: all RGB outputs 0, out_valid 0, commit 0, sprite_addr 0. All shadow and active registers are x=0, y=0, en=0. All pipeline registers are 0.

## Timing
- Output for the pixel presented at cycle t appears on the RGB outputs after edge t+2. out_valid follows valid with the same delay.
- There is no stall and no backpressure. One pixel per cycle, continuously.
- ROM contract: the block drives the address at edge t+1 and samples the data during cycle t+1, i.e. a synchronous ROM with one-cycle read.
- Sprites partially off-screen (x > H_ACTIVE - SPRITE_W) are clipped by valid. There is no wrap to column 0.
- Reset asserted mid-frame clears the outputs immediately (asynchronously). After release, sprites stay hidden until the first commit following new writes.

## Test plan
- Reset and background: bg_mode=0, bg_color=12'hABC, no sprites, full frame. Every valid pixel outputs 12'hABC two cycles later. Blanking pixels output 0. After rst_n drops, the outputs go to 0 without waiting for a clock edge.
- Single sprite: write idx0 x=100 y=50 en=1, and load the ROM with the address as data, giving 12'hnnn ≠ key. The next frame, pixel (100,50) outputs ROM[0] and (131,81) outputs ROM[1023]. Pixels (99,50) and (132,50) output the background.
- Priority and transparency: sprite 0 and sprite 1 overlap at (200,200). Sprite 0 data 12'h111 gives 12'h111. Sprite 0 data 12'h0F0 (the key) gives sprite 1's colour. Both keyed gives the background.
- Double-buffer: write new x mid-frame (v=100). The sprite stays at the old position for the rest of that frame. commit pulses once at (0,480). The new position is visible the next frame. A write issued exactly on the commit cycle appears one frame later.
- Mouse and edges: enable_mouse_display with mouse_pixel=12'hFFF over a sprite gives 12'hFFF. A sprite at x=620 is drawn at columns 620..639 only. cfg_idx=7 with NUM_SPRITES=4 changes nothing.

Source files
------------

// File: rtl/sprite_pixel_compositor.sv
// Two-stage pixel compositor: background, prioritised ROM sprites, mouse cursor.
// Sprite positions are double-buffered and swap at the frame boundary.
module sprite_pixel_compositor #(
    parameter int          NUM_SPRITES = 4,
    parameter int          SPRITE_W    = 32,
    parameter int          SPRITE_H    = 32,
    parameter int          H_ACTIVE    = 640,
    parameter int          V_ACTIVE    = 480,
    parameter logic [11:0] TRANSPARENT = 12'h0F0,
    parameter int          LATENCY     = 2,
    localparam int         AW          = $clog2(SPRITE_W * SPRITE_H),
    localparam int         XW          = $clog2(SPRITE_W),
    localparam int         YW          = AW - XW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [9:0]                h_cnt,
    input  logic [9:0]                v_cnt,
    input  logic                      valid,
    input  logic                      enable_mouse_display,
    input  logic [11:0]               mouse_pixel,
    input  logic [1:0]                bg_mode,
    input  logic [11:0]               bg_color,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_idx,
    input  logic [9:0]                cfg_x,
    input  logic [9:0]                cfg_y,
    input  logic                      cfg_en,
    output logic [NUM_SPRITES*AW-1:0] sprite_addr,
    input  logic [NUM_SPRITES*12-1:0] sprite_data,
    output logic                      commit,
    output logic                      out_valid,
    output logic [3:0]                vgaRed,
    output logic [3:0]                vgaGreen,
    output logic [3:0]                vgaBlue
);

    localparam logic [10:0] SW11 = 11'(SPRITE_W);
    localparam logic [10:0] SH11 = 11'(SPRITE_H);
    localparam logic [9:0]  VA10 = 10'(V_ACTIVE);

    logic [9:0]                r_sh_x   [NUM_SPRITES];
    logic [9:0]                r_sh_y   [NUM_SPRITES];
    logic                      r_sh_en  [NUM_SPRITES];
    logic [9:0]                r_act_x  [NUM_SPRITES];
    logic [9:0]                r_act_y  [NUM_SPRITES];
    logic                      r_act_en [NUM_SPRITES];
    logic                      r_commit;
    logic [NUM_SPRITES*AW-1:0] r_addr;
    logic [NUM_SPRITES-1:0]    r_hit;
    logic [11:0]               r_bg;
    logic                      r_men;
    logic [11:0]               r_mpix;
    logic                      r_valid;
    logic [11:0]               r_rgb;
    logic                      r_ovalid;

    logic                      w_commit;
    logic [NUM_SPRITES-1:0]    w_hit;
    logic [AW-1:0]             w_addr   [NUM_SPRITES];
    logic [11:0]               w_bg;
    logic [11:0]               w_pix;
    logic                      w_found;
    logic [11:0]               w_spr;

    assign w_commit = (h_cnt == 10'd0) && (v_cnt == VA10);

    // Shadow writes and the frame-boundary copy into the active set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_sh_x[i]   <= '0;
                r_sh_y[i]   <= '0;
                r_sh_en[i]  <= 1'b0;
                r_act_x[i]  <= '0;
                r_act_y[i]  <= '0;
                r_act_en[i] <= 1'b0;
            end
        end else begin
            r_commit <= w_commit;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (cfg_we && int'(cfg_idx) == i) begin
                    r_sh_x[i]  <= cfg_x;
                    r_sh_y[i]  <= cfg_y;
                    r_sh_en[i] <= cfg_en;
                end
                if (w_commit) begin
                    r_act_x[i]  <= r_sh_x[i];
                    r_act_y[i]  <= r_sh_y[i];
                    r_act_en[i] <= r_sh_en[i];
                end
            end
        end
    end

    // Stage 1: hit test and ROM address per sprite, in 11 bits to avoid wrap.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            w_hit[i] = r_act_en[i]
                && ({1'b0, h_cnt} >= {1'b0, r_act_x[i]})
                && ({1'b0, h_cnt} <  {1'b0, r_act_x[i]} + SW11)
                && ({1'b0, v_cnt} >= {1'b0, r_act_y[i]})
                && ({1'b0, v_cnt} <  {1'b0, r_act_y[i]} + SH11);
            w_addr[i] = {v_cnt[YW-1:0] - r_act_y[i][YW-1:0],
                         h_cnt[XW-1:0] - r_act_x[i][XW-1:0]};
        end
    end

    // Stage 1: background pattern.
    always_comb begin
        w_bg = 12'h000;
        unique case (bg_mode)
            2'd0: w_bg = bg_color;
            2'd1: w_bg = (h_cnt[4] ^ v_cnt[4]) ? 12'h000 : bg_color;
            2'd2: w_bg = {v_cnt[8:5], v_cnt[8:5], 4'hF};
            2'd3: w_bg = 12'h000;
        endcase
    end

    // Stage 1 registers; addresses hold when the sprite is not hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_hit   <= '0;
            r_bg    <= '0;
            r_men   <= 1'b0;
            r_mpix  <= '0;
            r_valid <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (w_hit[i]) r_addr[i*AW +: AW] <= w_addr[i];
            end
            r_hit   <= w_hit;
            r_bg    <= w_bg;
            r_men   <= enable_mouse_display;
            r_mpix  <= mouse_pixel;
            r_valid <= valid;
        end
    end

    // Stage 2: blanking, then cursor, then lowest-index opaque sprite, then background.
    always_comb begin
        w_found = 1'b0;
        w_spr   = 12'h000;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (!w_found && r_hit[i] && sprite_data[i*12 +: 12] != TRANSPARENT) begin
                w_found = 1'b1;
                w_spr   = sprite_data[i*12 +: 12];
            end
        end
        if (!r_valid)     w_pix = 12'h000;
        else if (r_men)   w_pix = r_mpix;
        else if (w_found) w_pix = w_spr;
        else              w_pix = r_bg;
    end

    // Stage 2 output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb    <= '0;
            r_ovalid <= 1'b0;
        end else begin
            r_rgb    <= w_pix;
            r_ovalid <= r_valid;
        end
    end

    assign sprite_addr = r_addr;
    assign commit      = r_commit;
    assign out_valid   = r_ovalid;
    assign vgaRed      = r_rgb[11:8];
    assign vgaGreen    = r_rgb[7:4];
    assign vgaBlue     = r_rgb[3:0];

endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Directed bench for sprite_pixel_compositor with a two-deep expected-pixel queue.
// ROMs are modelled as arrays read from the registered sprite address.
module tb_sprite_pixel_compositor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  h_cnt, v_cnt;
    logic        valid;
    logic        enable_mouse_display;
    logic [11:0] mouse_pixel;
    logic [1:0]  bg_mode;
    logic [11:0] bg_color;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic [9:0]  cfg_x, cfg_y;
    logic        cfg_en;
    logic [39:0] sprite_addr;
    logic [47:0] sprite_data;
    logic        commit, out_valid;
    logic [3:0]  vgaRed, vgaGreen, vgaBlue;

    always #5 clk = ~clk;

    sprite_pixel_compositor dut (
        .clk(clk), .rst_n(rst_n), .h_cnt(h_cnt), .v_cnt(v_cnt), .valid(valid),
        .enable_mouse_display(enable_mouse_display), .mouse_pixel(mouse_pixel),
        .bg_mode(bg_mode), .bg_color(bg_color), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_en(cfg_en), .sprite_addr(sprite_addr),
        .sprite_data(sprite_data), .commit(commit), .out_valid(out_valid),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
    );

    logic [11:0] rom [4][1024];

    always_comb begin
        sprite_data = '0;
        for (int i = 0; i < 4; i++)
            sprite_data[i*12 +: 12] = rom[i][sprite_addr[i*10 +: 10]];
    end

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        vl;
        logic [11:0] c;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic        g_we = 1'b0;
    logic [2:0]  g_idx = '0;
    logic [9:0]  g_x = '0, g_y = '0;
    logic        g_en = 1'b0;
    logic [1:0]  g_mode = 2'd0;
    logic [11:0] g_bgc = 12'hABC;
    logic        g_men = 1'b0;
    logic [11:0] g_mpix = 12'h000;
    logic        exp_cmt = 1'b0;

    localparam logic [11:0] BG = 12'hABC;

    task automatic step(input logic [9:0] hh, input logic [9:0] vv,
                        input logic vl, input logic [11:0] ex);
        exp_t e;
        @(negedge clk);
        n_vec++;
        assert (commit === exp_cmt) else begin
            n_err++;
            $error("FAIL commit h=%0d v=%0d got %b exp %b", h_cnt, v_cnt, commit, exp_cmt);
        end
        if (q.size() >= 2) begin
            e = q.pop_front();
            n_vec++;
            assert ({out_valid, vgaRed, vgaGreen, vgaBlue} === {e.vl, e.c}) else begin
                n_err++;
                $error("FAIL pix h=%0d v=%0d got %b/%h exp %b/%h", e.h, e.v,
                       out_valid, {vgaRed, vgaGreen, vgaBlue}, e.vl, e.c);
            end
        end
        h_cnt = hh;
        v_cnt = vv;
        valid = vl;
        bg_mode = g_mode;
        bg_color = g_bgc;
        enable_mouse_display = g_men;
        mouse_pixel = g_mpix;
        cfg_we = g_we;
        cfg_idx = g_idx;
        cfg_x = g_x;
        cfg_y = g_y;
        cfg_en = g_en;
        g_we = 1'b0;
        exp_cmt = (hh == 10'd0) && (vv == 10'd480);
        e.h = hh;
        e.v = vv;
        e.vl = vl;
        e.c = ex;
        q.push_back(e);
    endtask

    task automatic wr(input logic [2:0] i, input logic [9:0] x,
                      input logic [9:0] y, input logic en);
        g_we = 1'b1;
        g_idx = i;
        g_x = x;
        g_y = y;
        g_en = en;
    endtask

    task automatic flush();
        step(10'd700, 10'd500, 1'b0, 12'h000);
        step(10'd700, 10'd500, 1'b0, 12'h000);
    endtask

    initial begin
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 1024; a++)
                rom[s][a] = {2'(s + 1), 10'(a)};
        rst_n = 1'b0;
        h_cnt = '0; v_cnt = '0; valid = 1'b0;
        enable_mouse_display = 1'b0; mouse_pixel = '0;
        bg_mode = '0; bg_color = BG;
        cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0; cfg_en = 1'b0;

        #3;
        n_vec++;
        assert ({out_valid, commit, vgaRed, vgaGreen, vgaBlue, sprite_addr} === '0) else begin
            n_err++;
            $error("FAIL reset got %b %b %h %h exp zeros", out_valid, commit,
                   {vgaRed, vgaGreen, vgaBlue}, sprite_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;

        step(10'd0, 10'd0, 1'b1, BG);
        step(10'd639, 10'd479, 1'b1, BG);
        step(10'd700, 10'd10, 1'b0, 12'h000);

        g_mode = 2'd1;
        step(10'd16, 10'd0, 1'b1, 12'h000);
        step(10'd16, 10'd16, 1'b1, BG);
        step(10'd5, 10'd3, 1'b1, BG);
        g_mode = 2'd2;
        step(10'd0, 10'd255, 1'b1, 12'h77F);
        step(10'd0, 10'd479, 1'b1, 12'hEEF);
        g_mode = 2'd3;
        step(10'd10, 10'd10, 1'b1, 12'h000);
        g_mode = 2'd0;

        wr(3'd0, 10'd100, 10'd50, 1'b1);
        step(10'd100, 10'd50, 1'b1, BG);
        step(10'd100, 10'd50, 1'b1, BG);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        step(10'd100, 10'd50, 1'b1, 12'h400);
        step(10'd131, 10'd81, 1'b1, 12'h7FF);
        step(10'd99, 10'd50, 1'b1, BG);
        step(10'd132, 10'd50, 1'b1, BG);
        step(10'd100, 10'd49, 1'b1, BG);
        step(10'd100, 10'd82, 1'b1, BG);

        wr(3'd0, 10'd200, 10'd200, 1'b1);
        step(10'd5, 10'd5, 1'b1, BG);
        wr(3'd1, 10'd200, 10'd200, 1'b1);
        step(10'd5, 10'd5, 1'b1, BG);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        flush();
        rom[0][0] = 12'h111;
        step(10'd200, 10'd200, 1'b1, 12'h111);
        flush();
        rom[0][0] = 12'h0F0;
        step(10'd200, 10'd200, 1'b1, 12'h800);
        flush();
        rom[1][0] = 12'h0F0;
        step(10'd200, 10'd200, 1'b1, BG);
        flush();
        rom[0][0] = 12'h400;
        rom[1][0] = 12'h800;
        g_men = 1'b1;
        g_mpix = 12'hFFF;
        step(10'd200, 10'd200, 1'b1, 12'hFFF);
        g_men = 1'b0;
        step(10'd201, 10'd200, 1'b1, 12'h401);

        wr(3'd0, 10'd300, 10'd200, 1'b1);
        step(10'd5, 10'd100, 1'b1, BG);
        step(10'd200, 10'd200, 1'b1, 12'h400);
        step(10'd300, 10'd200, 1'b1, BG);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        step(10'd300, 10'd200, 1'b1, 12'h400);
        step(10'd200, 10'd200, 1'b1, 12'h800);

        wr(3'd0, 10'd400, 10'd200, 1'b1);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        step(10'd400, 10'd200, 1'b1, BG);
        step(10'd300, 10'd200, 1'b1, 12'h400);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        step(10'd400, 10'd200, 1'b1, 12'h400);
        step(10'd300, 10'd200, 1'b1, BG);

        wr(3'd2, 10'd620, 10'd0, 1'b1);
        step(10'd5, 10'd100, 1'b1, BG);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        step(10'd620, 10'd0, 1'b1, 12'hC00);
        step(10'd639, 10'd0, 1'b1, 12'hC13);
        step(10'd640, 10'd0, 1'b0, 12'h000);
        step(10'd0, 10'd0, 1'b1, BG);
        step(10'd619, 10'd0, 1'b1, BG);

        wr(3'd7, 10'd0, 10'd0, 1'b1);
        step(10'd5, 10'd100, 1'b1, BG);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        step(10'd0, 10'd0, 1'b1, BG);
        step(10'd1, 10'd1, 1'b1, BG);

        step(10'd639, 10'd0, 1'b1, 12'hC13);
        step(10'd700, 10'd0, 1'b0, 12'h000);
        @(posedge clk);
        #2;
        n_vec++;
        assert ({out_valid, vgaRed} === {1'b1, 4'hC}) else begin
            n_err++;
            $error("FAIL prereset got %b/%h exp 1/c", out_valid, vgaRed);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        assert ({out_valid, commit, vgaRed, vgaGreen, vgaBlue} === '0) else begin
            n_err++;
            $error("FAIL asyncreset got %b %b %h exp zeros", out_valid, commit,
                   {vgaRed, vgaGreen, vgaBlue});
        end
        q.delete();
        exp_cmt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(10'd400, 10'd200, 1'b1, BG);
        step(10'd620, 10'd0, 1'b1, BG);
        step(10'd0, 10'd480, 1'b0, 12'h000);
        step(10'd400, 10'd200, 1'b1, BG);
        step(10'd620, 10'd0, 1'b1, BG);
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
